// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, the bubble
// instruction and the fetch FSM state encoding.
package inst_fetch_unit_pkg;

   localparam int          DEF_PC_WIDTH   = 32;
   localparam int          DEF_INST_WIDTH = 32;
   localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_KILL = 3'd4
   } ifu_state_t;

endpackage

// File: rtl/inst_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load or bubble.
// With IFU_MISALIGN_CHK_EN defined it also carries the misaligned-fetch flag.
module inst_fetch_unit_if_id_reg
   import inst_fetch_unit_pkg::*;
#(
   parameter int                    PC_WIDTH   = DEF_PC_WIDTH,
   parameter int                    INST_WIDTH = DEF_INST_WIDTH,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = DEF_NOP_INST
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  stall,
   input  logic                  load,
   input  logic [PC_WIDTH-1:0]   load_pc,
   input  logic [INST_WIDTH-1:0] load_inst,
`ifdef IFU_MISALIGN_CHK_EN
   input  logic                  load_misalign,
   output logic                  misalign,
`endif
   output logic                  valid,
   output logic [PC_WIDTH-1:0]   pc,
   output logic [INST_WIDTH-1:0] inst
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= NOP_INST;
      end else if (flush) begin
         // pc is left alone on flush; only the payload is squashed
         valid <= 1'b0;
         inst  <= NOP_INST;
      end else if (!stall) begin
         if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
         end else begin
            valid <= 1'b0;
            inst  <= NOP_INST;
         end
      end
   end

`ifdef IFU_MISALIGN_CHK_EN
   // The flag follows loads and flushes only; bubbles leave it untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign <= 1'b0;
      end else if (flush) begin
         misalign <= 1'b0;
      end else if (!stall && load) begin
         misalign <= load_misalign;
      end
   end
`endif

endmodule

// File: rtl/inst_fetch_unit.sv
// IF stage: one-outstanding-request fetch FSM feeding the IF/ID register.
// Optional IFU_MISALIGN_CHK_EN adds if_id_misalign and suppresses misaligned fetches.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int                    PC_WIDTH   = DEF_PC_WIDTH,
   parameter int                    INST_WIDTH = DEF_INST_WIDTH,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = DEF_NOP_INST
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic                  flush,
   input  logic                  stall,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic                  imem_rvalid,
   input  logic [INST_WIDTH-1:0] imem_rdata,
   output logic                  fetch_stall,
`ifdef IFU_MISALIGN_CHK_EN
   output logic                  if_id_misalign,
`endif
   output logic                  if_id_valid,
   output logic [PC_WIDTH-1:0]   if_id_pc,
   output logic [INST_WIDTH-1:0] if_id_inst
);

   ifu_state_t            state_reg, state_next;
   logic [PC_WIDTH-1:0]   req_pc_reg;
   logic [INST_WIDTH-1:0] hold_buf_reg;

   logic                  deliver;
   logic [PC_WIDTH-1:0]   deliver_pc;
   logic [INST_WIDTH-1:0] deliver_inst;
   logic                  capture_hold;

   assign imem_addr   = {pc[PC_WIDTH-1:2], 2'b00};
   // Released during flush as well, so program_counter loads the branch target
   assign fetch_stall = !flush && !deliver;

   always_comb begin
      state_next   = state_reg;
      imem_req     = 1'b0;
      deliver      = 1'b0;
      deliver_pc   = req_pc_reg;
      deliver_inst = imem_rdata;
      capture_hold = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_REQ;
         S_REQ: begin
            if (!flush) begin
`ifdef IFU_MISALIGN_CHK_EN
               if (pc[1:0] != 2'b00) begin
                  // No memory access; hand a bubble marked misaligned downstream
                  if (!stall) begin
                     deliver      = 1'b1;
                     deliver_pc   = pc;
                     deliver_inst = NOP_INST;
                  end
               end else
`endif
               begin
                  imem_req   = 1'b1;
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_next = imem_rvalid ? S_REQ : S_KILL;
            end else if (imem_rvalid) begin
               if (stall) begin
                  capture_hold = 1'b1;
                  state_next   = S_HOLD;
               end else begin
                  deliver    = 1'b1;
                  state_next = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (flush) begin
               state_next = S_REQ;
            end else if (!stall) begin
               deliver      = 1'b1;
               deliver_inst = hold_buf_reg;
               state_next   = S_REQ;
            end
         end
         // The stale response must drain before a new request may issue
         S_KILL: begin
            if (imem_rvalid) state_next = S_REQ;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         req_pc_reg   <= '0;
         hold_buf_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (imem_req)     req_pc_reg   <= pc;
         if (capture_hold) hold_buf_reg <= imem_rdata;
      end
   end

   inst_fetch_unit_if_id_reg #(
      .PC_WIDTH   (PC_WIDTH),
      .INST_WIDTH (INST_WIDTH),
      .NOP_INST   (NOP_INST)
   ) u_if_id_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .stall         (stall),
      .load          (deliver),
      .load_pc       (deliver_pc),
      .load_inst     (deliver_inst),
`ifdef IFU_MISALIGN_CHK_EN
      .load_misalign (state_reg == S_REQ),
      .misalign      (if_id_misalign),
`endif
      .valid         (if_id_valid),
      .pc            (if_id_pc),
      .inst          (if_id_inst)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios, then randomized stall/flush/latency
// checked against a program-order model of the IF/ID stream.
module tb_inst_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = '0;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        fetch_stall;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;
`ifdef IFU_MISALIGN_CHK_EN
   logic        if_id_misalign;
`endif

   inst_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .flush          (flush),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .fetch_stall    (fetch_stall),
`ifdef IFU_MISALIGN_CHK_EN
      .if_id_misalign (if_id_misalign),
`endif
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_inst     (if_id_inst)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_del = 0;
   int          lat = 1;
   logic [31:0] target = '0;
   logic [31:0] ovr [logic [31:0]];

   // Values sampled at the most recent negedge
   logic        s_req, s_fs, s_valid;
   logic [31:0] s_addr, s_ifpc, s_inst;

   // Expected IF/ID contents
   logic        m_valid = 1'b0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_inst = NOP;
   logic        m_mis = 1'b0;

   function automatic logic [31:0] mem_at(input logic [31:0] a);
      if (ovr.exists(a)) return ovr[a];
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_pc    = '0;
      m_inst  = NOP;
      m_mis   = 1'b0;
   endtask

   // One clock: compare IF/ID with the model, advance the model and the program counter
   task automatic tick();
      @(negedge clk);
      s_req = imem_req;  s_fs = fetch_stall;  s_addr = imem_addr;
      s_valid = if_id_valid;  s_ifpc = if_id_pc;  s_inst = if_id_inst;
      check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check("if_id_pc", if_id_pc, m_pc);
      check("if_id_inst", if_id_inst, m_inst);
`ifdef IFU_MISALIGN_CHK_EN
      check("if_id_misalign", 32'(if_id_misalign), 32'(m_mis));
`endif
      if (imem_req) check("imem_addr", imem_addr, {pc[31:2], 2'b00});
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_valid = 1'b0;
         m_inst  = NOP;
         m_mis   = 1'b0;
      end else if (!stall) begin
         if (!fetch_stall) begin
            n_del++;
            m_valid = 1'b1;
            m_pc    = pc;
`ifdef IFU_MISALIGN_CHK_EN
            m_mis  = (pc[1:0] != 2'b00);
            m_inst = m_mis ? NOP : mem_at(pc);
`else
            m_inst = mem_at(pc);
`endif
         end else begin
            m_valid = 1'b0;
            m_inst  = NOP;
         end
      end
      @(posedge clk);
      #1;
      if (rst_n) pc = flush ? target : (s_fs ? pc : pc + 32'd4);
   endtask

   task automatic wait_req();
      for (int k = 0; k < 20; k++) begin
         tick();
         if (s_req) return;
      end
      check("wait_req_timeout", 32'(s_req), 32'd1);
   endtask

   // Memory: one response per request after lat cycles, garbage data otherwise
   initial begin
      int          cnt;
      logic        pend;
      logic        req_seen;
      logic [31:0] a_seen, rd;
      cnt = 0; pend = 1'b0; rd = '0;
      forever begin
         @(negedge clk);
         req_seen = imem_req && rst_n;
         a_seen   = imem_addr;
         if (req_seen) check("one_outstanding", 32'(pend), 32'd0);
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom();
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (req_seen) begin
               pend = 1'b1;
               cnt  = lat;
               rd   = mem_at(a_seen);
            end
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = rd;
                  pend        = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int del0;
      int found;
      ovr[32'h0000_000C] = 32'h0050_0093;
      repeat (3) tick();
      rst_n = 1'b1;

      // Test 1: 1-cycle memory, sequential fetch
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("t1_req[%0d]", i), 32'(s_req), 32'(i % 2));
         check($sformatf("t1_fs[%0d]", i), 32'(s_fs), 32'((i == 0) || (i % 2 == 1)));
         if (i % 2 == 1) check($sformatf("t1_addr[%0d]", i), s_addr, 32'(((i - 1) / 2) * 4));
         if (i >= 3) begin
            check($sformatf("t1_ifpc[%0d]", i), s_ifpc, 32'(((i - 3) / 2) * 4));
            check($sformatf("t1_valid[%0d]", i), 32'(s_valid), 32'(i % 2));
         end
      end

      // Test 2: hazard stall while the response for pc 12 arrives
      stall = 1'b1;
      tick();
      check("t2_fs_capture", 32'(s_fs), 32'd1);
      tick();
      check("t2_fs_hold", 32'(s_fs), 32'd1);
      check("t2_no_req", 32'(s_req), 32'd0);
      check("t2_ifpc_held", s_ifpc, 32'd8);
      stall = 1'b0;
      lat = 3;
      ovr[32'h0000_0010] = 32'hDEAD_BEEF;
      tick();
      check("t2_fs_release", 32'(s_fs), 32'd0);
      tick();
      check("t2_inst", s_inst, 32'h0050_0093);
      check("t2_ifpc", s_ifpc, 32'd12);
      check("t2_valid", 32'(s_valid), 32'd1);
      check("t2_next_addr", s_addr, 32'd16);

      // Test 3: flush while waiting; stale DEADBEEF must be dropped
      flush = 1'b1;
      target = 32'h100;
      tick();
      check("t3_fs_flush", 32'(s_fs), 32'd0);
      flush = 1'b0;
      tick();
      check("t3_kill_noreq_a", 32'(s_req), 32'd0);
      tick();
      check("t3_kill_noreq_b", 32'(s_req), 32'd0);
      lat = 1;
      tick();
      check("t3_req", 32'(s_req), 32'd1);
      check("t3_addr", s_addr, 32'h100);
      check("t3_valid", 32'(s_valid), 32'd0);

      // Test 4: flush coincident with rvalid
      flush = 1'b1;
      target = 32'h200;
      tick();
      check("t4_fs_flush", 32'(s_fs), 32'd0);
      flush = 1'b0;
      tick();
      check("t4_req", 32'(s_req), 32'd1);
      check("t4_addr", s_addr, 32'h200);
      check("t4_valid", 32'(s_valid), 32'd0);
      check("t4_inst", s_inst, NOP);
      check("t4_ifpc_kept", s_ifpc, 32'd12);

      // Random phase
      del0 = n_del;
      for (int i = 0; i < 600; i++) begin
         stall  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 11) == 0);
         target = 32'($urandom_range(0, 1023)) << 2;
         lat    = int'($urandom_range(1, 4));
         tick();
      end
      stall = 1'b0;
      flush = 1'b0;
      check("rand_progress", 32'((n_del - del0) > 50), 32'd1);

      // Test 5: asynchronous reset while a request is outstanding
      lat = 4;
      wait_req();
      rst_n = 1'b0;
      pc = '0;
      #1;
      check("t5_req", 32'(imem_req), 32'd0);
      check("t5_valid", 32'(if_id_valid), 32'd0);
      check("t5_ifpc", if_id_pc, 32'd0);
      check("t5_inst", if_id_inst, NOP);
      model_reset();
      lat = 1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("t5_idle_noreq", 32'(s_req), 32'd0);
      tick();
      check("t5_first_req", 32'(s_req), 32'd1);
      check("t5_first_addr", s_addr, 32'd0);

`ifdef IFU_MISALIGN_CHK_EN
      // Test 6: misaligned pc is not fetched
      flush = 1'b1;
      target = 32'h102;
      tick();
      flush = 1'b0;
      found = 0;
      for (int k = 0; k < 12 && found == 0; k++) begin
         tick();
         if (!s_fs) found = 1;
      end
      check("t6_delivered", 32'(found), 32'd1);
      check("t6_no_req", 32'(s_req), 32'd0);
      tick();
      check("t6_misalign", 32'(if_id_misalign), 32'd1);
      check("t6_inst", s_inst, NOP);
      check("t6_ifpc", s_ifpc, 32'h102);
      check("t6_valid", 32'(s_valid), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
